aes32_dsi_dsmi_esi: RTL and testbench

AES32_DSI_DSMI_ESI -- requirements
Module: aes32_dsi_dsmi_esi

---
 rtl/aes32_dsi_dsmi_esi_if.sv | 21 ++
 rtl/aes32_dsi_dsmi_esi.sv | 115 +++++++++++
 tb/tb_aes32_dsi_dsmi_esi.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes32_dsi_dsmi_esi_if.sv
// Operand/result bundle for the AES-32 single-round-step unit.
// The master drives the operands and the slave returns the registered result.
interface aes32_dsi_dsmi_esi_if;
    logic [1:0]  op;
    logic        in_valid;
    logic [1:0]  bs;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic        out_valid;

    modport master (
        output op, in_valid, bs, rs1, rs2,
        input  rd, out_valid
    );

    modport slave (
        input  op, in_valid, bs, rs1, rs2,
        output rd, out_valid
    );
endinterface

// File: rtl/aes32_dsi_dsmi_esi.sv
// AES-32 byte step: one S-box lookup (forward or inverse), optional InvMixColumns
// column contribution, rotated into place and XORed into rs1; one-cycle latency.
module aes32_dsi_dsmi_esi (
    input  logic                      clk,
    input  logic                      rst,
    aes32_dsi_dsmi_esi_if.slave       bus
);
    localparam logic [1:0] OP_ESI  = 2'b00;
    localparam logic [1:0] OP_DSI  = 2'b01;
    localparam logic [1:0] OP_DSMI = 2'b10;

    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [1:0] b);
        logic [31:0] r;
        case (b)
            2'd0:    r = x;
            2'd1:    r = {x[23:0], x[31:24]};
            2'd2:    r = {x[15:0], x[31:16]};
            default: r = {x[7:0],  x[31:8]};
        endcase
        return r;
    endfunction

    logic [7:0]  si;
    logic [7:0]  so_fwd;
    logic [7:0]  so_inv;
    logic [31:0] mixed;
    logic [31:0] word;
    logic [31:0] result_p0;
    logic [31:0] rd_p1;
    logic        vld_p1;

    // Stage p0: byte select, S-box, column contribution, rotate and accumulate.
    always_comb begin
        si     = bus.rs2[{bus.bs, 3'b000} +: 8];
        so_fwd = FWD_SBOX[si];
        so_inv = INV_SBOX[si];
        mixed  = {gmul(so_inv, 8'h0b), gmul(so_inv, 8'h0d),
                  gmul(so_inv, 8'h09), gmul(so_inv, 8'h0e)};
        case (bus.op)
            OP_ESI:  word = {24'h0, so_fwd};
            OP_DSI:  word = {24'h0, so_inv};
            OP_DSMI: word = mixed;
            default: word = 32'h0;    // reserved op passes rs1 through
        endcase
        result_p0 = bus.rs1 ^ rol32(word, bus.bs);
    end

    // Stage p1: registered result and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_p1  <= 32'h0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) rd_p1 <= result_p0;
        end
    end

    assign bus.rd        = rd_p1;
    assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_aes32_dsi_dsmi_esi.sv
// Bench for aes32_dsi_dsmi_esi: reference S-boxes derived from GF(2^8) arithmetic,
// directed vectors, random ops, flow control, reset, key expansion and AES round trip.
module tb_aes32_dsi_dsmi_esi;
    logic clk = 1'b0;
    logic rst;
    aes32_dsi_dsmi_esi_if bus ();

    aes32_dsi_dsmi_esi dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sbox_m  [256];
    logic [7:0] isbox_m [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
        return (x << s) | (x >> (8 - s));
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int s);
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] b;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gf_mul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            b = inv;
            sbox_m[a] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) isbox_m[sbox_m[a]] = 8'(a);
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [1:0] bs,
                                           input logic [31:0] rs1, input logic [31:0] rs2);
        logic [7:0]  si;
        logic [7:0]  so;
        logic [31:0] w;
        int sh;
        sh = 8 * int'(bs);
        si = 8'(rs2 >> sh);
        case (op)
            2'd0: w = {24'h0, sbox_m[si]};
            2'd1: w = {24'h0, isbox_m[si]};
            2'd2: begin
                so = isbox_m[si];
                w  = {gf_mul(so, 8'h0b), gf_mul(so, 8'h0d), gf_mul(so, 8'h09), gf_mul(so, 8'h0e)};
            end
            default: return rs1;
        endcase
        return rs1 ^ rotl32(w, sh);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] u);
        logic [7:0]  a [4];
        logic [31:0] r;
        for (int k = 0; k < 4; k++) a[k] = u[8*k +: 8];
        r = 32'h0;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = gf_mul(a[k], 8'h02) ^ gf_mul(a[(k+1)%4], 8'h03) ^ a[(k+2)%4] ^ a[(k+3)%4];
        return r;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [1:0] bs, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic valid);
        bus.op       = op;
        bus.bs       = bs;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.in_valid = valid;
    endtask

    task automatic dut_op(input logic [1:0] op, input logic [1:0] bs, input logic [31:0] rs1,
                          input logic [31:0] rs2, output logic [31:0] r);
        drive(op, bs, rs1, rs2, 1'b1);
        @(posedge clk);
        #1;
        r = bus.rd;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'd0, 2'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        #3;
        n_checks++;
        if (bus.rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want %h", bus.rd, 32'h0); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", bus.out_valid); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd_clocked: got %h want %h", bus.rd, 32'h0); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vld_clocked: got %b want 0", bus.out_valid); end
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        logic [1:0]  v_op  [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        logic [1:0]  v_bs  [6] = '{2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1};
        logic [31:0] v_rs1 [6] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        logic [31:0] v_rs2 [6] = '{32'h0, 32'h5300_0000, 32'h0000_0063, 32'h0000_ED00,
                                   32'h0000_007C, 32'h0000_7C00};
        logic [31:0] v_exp [6] = '{32'h0000_0063, 32'hED00_0000, 32'h0000_0000, 32'hFFFF_ACFF,
                                   32'h0B0D_090E, 32'h0D09_0E0B};
        logic [31:0] r;
        for (int i = 0; i < 6; i++) begin
            dut_op(v_op[i], v_bs[i], v_rs1[i], v_rs2[i], r);
            n_checks++;
            if (r !== v_exp[i]) begin n_fail++; $display("FAIL vector%0d_rd: got %h want %h", i, r, v_exp[i]); end
            n_checks++;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL vector%0d_vld: got %b want 1", i, bus.out_valid); end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] exp_rd;
        logic        exp_vld;
        logic [1:0]  op;
        logic [1:0]  bs;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        valid;
        exp_rd = 32'h0;
        for (int i = 0; i < 400; i++) begin
            op    = 2'($urandom_range(0, 3));
            bs    = 2'($urandom_range(0, 3));
            rs1   = $urandom;
            rs2   = $urandom;
            valid = (i == 0) || ($urandom_range(0, 3) != 0);
            drive(op, bs, rs1, rs2, valid);
            @(posedge clk);
            #1;
            if (valid) exp_rd = ref_op(op, bs, rs1, rs2);
            exp_vld = valid;
            n_checks++;
            if (bus.rd !== exp_rd) begin
                n_fail++;
                $display("FAIL random%0d_rd (op=%0d bs=%0d): got %h want %h", i, op, bs, bus.rd, exp_rd);
            end
            n_checks++;
            if (bus.out_valid !== exp_vld) begin
                n_fail++;
                $display("FAIL random%0d_vld: got %b want %b", i, bus.out_valid, exp_vld);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_flow_control();
        logic [31:0] r;
        logic [31:0] junk;
        dut_op(2'd0, 2'd0, 32'h0, 32'h0, r);
        for (int i = 0; i < 3; i++) begin
            junk = $urandom;
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), junk, ~junk, 1'b0);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.rd !== 32'h0000_0063) begin n_fail++; $display("FAIL hold%0d_rd: got %h want %h", i, bus.rd, 32'h63); end
            n_checks++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold%0d_vld: got %b want 0", i, bus.out_valid); end
        end
        junk = $urandom;
        dut_op(2'd3, 2'd2, 32'hCAFE_F00D, junk, r);
        n_checks++;
        if (r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL reserved_rd: got %h want %h", r, 32'hCAFE_F00D); end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL reserved_vld: got %b want 1", bus.out_valid); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] r;
        dut_op(2'd0, 2'd3, 32'h0, 32'h5300_0000, r);
        n_checks++;
        if (r !== 32'hED00_0000) begin n_fail++; $display("FAIL pre_reset_rd: got %h want %h", r, 32'hED00_0000); end
        drive(2'd1, 2'd0, 32'h1234_5678, 32'h0000_0063, 1'b1);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.rd !== 32'h0) begin n_fail++; $display("FAIL async_reset_rd: got %h want 0", bus.rd); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_vld: got %b want 0", bus.out_valid); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd !== 32'h0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL inflight_discard: got %h/%b want 0/0", bus.rd, bus.out_valid);
        end
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd !== 32'h1234_5678) begin n_fail++; $display("FAIL post_reset_rd: got %h want %h", bus.rd, 32'h1234_5678); end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_vld: got %b want 1", bus.out_valid); end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd !== 32'h1234_5678 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got %h/%b want %h/0", bus.rd, bus.out_valid, 32'h1234_5678);
        end
    endtask

    task automatic test_key_expansion();
        logic [31:0] t;
        t = 32'h0100_0000 ^ 32'h0001_0203;
        for (int b = 0; b < 4; b++) dut_op(2'd0, 2'(b), t, 32'h0D0E_0F0C, t);
        n_checks++;
        if (t !== 32'hD6AA_74FD) begin n_fail++; $display("FAIL key_w4: got %h want %h", t, 32'hD6AA_74FD); end
    endtask

    task automatic test_round_trip();
        logic [31:0] rk [44];
        logic [31:0] dk [44];
        logic [31:0] s  [4];
        logic [31:0] ns [4];
        logic [31:0] pt [4] = '{32'h3322_1100, 32'h7766_5544, 32'hBBAA_9988, 32'hFFEE_DDCC};
        logic [31:0] ct [4] = '{32'hD8E0_C469, 32'h3004_7B6A, 32'h80B7_CDD8, 32'h5AC5_B470};
        logic [31:0] t;
        logic [31:0] e;
        logic [7:0]  rcon;
        rk[0] = 32'h0302_0100; rk[1] = 32'h0706_0504; rk[2] = 32'h0B0A_0908; rk[3] = 32'h0F0E_0D0C;
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = rk[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {24'h0, rcon};
                rcon = gf_mul(rcon, 8'h02);
            end
            rk[i] = rk[i-4] ^ t;
        end
        for (int j = 0; j < 4; j++) s[j] = pt[j] ^ rk[j];
        for (int r = 1; r < 10; r++) begin
            for (int j = 0; j < 4; j++) begin
                t = 32'h0;
                for (int b = 0; b < 4; b++) dut_op(2'd0, 2'(b), t, s[(j+b)%4], t);
                ns[j] = mix_col(t) ^ rk[4*r+j];
            end
            s = ns;
        end
        for (int j = 0; j < 4; j++) begin
            t = rk[40+j];
            for (int b = 0; b < 4; b++) dut_op(2'd0, 2'(b), t, s[(j+b)%4], t);
            ns[j] = t;
        end
        s = ns;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (s[j] !== ct[j]) begin n_fail++; $display("FAIL cipher_col%0d: got %h want %h", j, s[j], ct[j]); end
        end
        for (int r = 1; r < 10; r++)
            for (int j = 0; j < 4; j++) begin
                t = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    dut_op(2'd0, 2'(b), 32'h0, rk[4*r+j], e);
                    dut_op(2'd2, 2'(b), t, e, t);
                end
                dk[4*r+j] = t;
            end
        for (int j = 0; j < 4; j++) s[j] = s[j] ^ rk[40+j];
        for (int r = 9; r >= 1; r--) begin
            for (int j = 0; j < 4; j++) begin
                t = dk[4*r+j];
                for (int b = 0; b < 4; b++) dut_op(2'd2, 2'(b), t, s[(j+4-b)%4], t);
                ns[j] = t;
            end
            s = ns;
        end
        for (int j = 0; j < 4; j++) begin
            t = rk[j];
            for (int b = 0; b < 4; b++) dut_op(2'd1, 2'(b), t, s[(j+4-b)%4], t);
            ns[j] = t;
        end
        s = ns;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (s[j] !== pt[j]) begin n_fail++; $display("FAIL plain_col%0d: got %h want %h", j, s[j], pt[j]); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        drive(2'd0, 2'd0, 32'h0, 32'h0, 1'b0);
        build_tables();
        test_reset();
        test_vectors();
        test_random_back_to_back();
        test_flow_control();
        test_reset_midstream();
        test_key_expansion();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
